// File: rtl/cpu_pkg.sv
// Shared CPU definitions: RV32 major opcodes, one-hot code bit indices,
// fetch FSM state encoding and the canonical NOP instruction word.
package cpu_pkg;

  // RV32 major opcodes (insn[6:0])
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Bit positions inside the 10-bit one-hot opcode class
  localparam int CODE_JAL    = 0;
  localparam int CODE_JALR   = 1;
  localparam int CODE_AUIPC  = 2;
  localparam int CODE_LUI    = 3;
  localparam int CODE_BRANCH = 4;
  localparam int CODE_OP     = 5;
  localparam int CODE_STORE  = 6;
  localparam int CODE_OPIMM  = 7;
  localparam int CODE_LOAD   = 8;
  localparam int CODE_MISC   = 9;
  localparam int CODE_W      = 10;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2,
    ST_ERR   = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational map from a 7-bit major opcode to the 10-bit one-hot
// opcode class. Unknown opcodes give all zeros. Shared with the decoder.
module opcode_classifier
  import cpu_pkg::*;
(
  input  logic [6:0]        i_opcode,
  output logic [CODE_W-1:0] o_code
);

  // One-hot class lookup; default leaves every bit clear
  always_comb begin
    o_code = '0;
    case (i_opcode)
      OPC_JAL:    o_code[CODE_JAL]    = 1'b1;
      OPC_JALR:   o_code[CODE_JALR]   = 1'b1;
      OPC_AUIPC:  o_code[CODE_AUIPC]  = 1'b1;
      OPC_LUI:    o_code[CODE_LUI]    = 1'b1;
      OPC_BRANCH: o_code[CODE_BRANCH] = 1'b1;
      OPC_OP:     o_code[CODE_OP]     = 1'b1;
      OPC_STORE:  o_code[CODE_STORE]  = 1'b1;
      OPC_OPIMM:  o_code[CODE_OPIMM]  = 1'b1;
      OPC_LOAD:   o_code[CODE_LOAD]   = 1'b1;
      OPC_FENCE,
      OPC_SYSTEM: o_code[CODE_MISC]   = 1'b1;
      default:    o_code              = '0;
    endcase
  end

endmodule

// File: rtl/insn_fetch_stage.sv
// Instruction fetch stage: holds the PC, fetches one word over a req/ack
// handshake, latches it into IR with its one-hot opcode class and holds it
// until execute strobes pc_update. A fetch that sees no ack within
// IMEM_TIMEOUT request cycles (0 = wait forever) parks the stage in a
// sticky error state that only reset leaves.
// Optional build macro FETCH_ILLEGAL_TRAP_EN adds the illegal_insn output:
// an unknown opcode or misaligned pc_next redirects the PC to RESET_PC.
module insn_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              pc_update,
  input  logic [31:0]       pc_next,
  output logic [31:0]       pc,
  output logic [31:0]       insn,
  output logic [CODE_W-1:0] code,
`ifdef FETCH_ILLEGAL_TRAP_EN
  output logic              illegal_insn,
`endif
  output logic              insn_valid,
  output logic              fetch_err
);

  localparam logic [31:0] TO_LIMIT = 32'(IMEM_TIMEOUT);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic              r_req;
  logic [31:0]       r_addr;
  logic [31:0]       r_pc;
  logic [31:0]       r_insn;
  logic [CODE_W-1:0] r_code;
  logic              r_valid;
  logic              r_err;
  logic [31:0]       r_cnt;

  logic [CODE_W-1:0] w_code_new;
  logic              w_to_hit;
  logic              w_go_req;
  logic              w_capture;
  logic              w_timeout;
  logic              w_pc_load;
  logic              w_cnt_inc;
  logic [31:0]       w_pc_new;

  opcode_classifier u_classifier (
    .i_opcode (imem_rdata[6:0]),
    .o_code   (w_code_new)
  );

  // Timeout fires when this no-ack cycle would bring the count to the limit
  assign w_to_hit = (TO_LIMIT != 32'd0) && ((r_cnt + 32'd1) == TO_LIMIT);

`ifdef FETCH_ILLEGAL_TRAP_EN
  logic r_illegal;
  logic w_misaligned;
  assign w_misaligned = (pc_next[1:0] != 2'b00);
  assign w_pc_new     = ((r_code == '0) || w_misaligned) ? RESET_PC
                                                         : (pc_next & ~32'h3);
`else
  assign w_pc_new     = pc_next & ~32'h3;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_BOOT;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic and per-cycle datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_go_req    = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_pc_load   = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_REQ;
        w_go_req    = 1'b1;
      end
      ST_REQ: begin
        if (imem_ack) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_VALID;
        end else if (w_to_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_ERR;
        end else begin
          w_cnt_inc   = 1'b1;
        end
      end
      ST_VALID: begin
        if (pc_update) begin
          w_pc_load   = 1'b1;
          w_go_req    = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_ERR:  w_state_nxt = ST_ERR;
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  // Fetch datapath: PC, request/address, IR, opcode class, flags, counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req   <= 1'b0;
      r_addr  <= 32'h0;
      r_pc    <= RESET_PC;
      r_insn  <= NOP_INSN;
      r_code  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= 32'h0;
    end else begin
      if (w_go_req) begin
        r_req  <= 1'b1;
        r_addr <= w_pc_load ? w_pc_new : r_pc;
        r_cnt  <= 32'h0;
      end
      if (w_pc_load) begin
        r_pc    <= w_pc_new;
        r_valid <= 1'b0;
      end
      if (w_cnt_inc) r_cnt <= r_cnt + 32'd1;
      if (w_capture) begin
        r_insn  <= imem_rdata;
        r_code  <= w_code_new;
        r_valid <= 1'b1;
        r_req   <= 1'b0;
        r_cnt   <= 32'h0;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
        r_req <= 1'b0;
      end
    end
  end

`ifdef FETCH_ILLEGAL_TRAP_EN
  // Illegal flag: set for unknown opcodes or misaligned redirects, cleared in REQ
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_illegal <= 1'b0;
    end else if (r_state == ST_REQ) begin
      r_illegal <= w_capture && (w_code_new == '0);
    end else if (w_pc_load) begin
      r_illegal <= r_illegal || w_misaligned;
    end
  end
  assign illegal_insn = r_illegal;
`endif

  assign imem_req   = r_req;
  assign imem_addr  = r_addr;
  assign pc         = r_pc;
  assign insn       = r_insn;
  assign code       = r_code;
  assign insn_valid = r_valid;
  assign fetch_err  = r_err;

endmodule

// File: tb/tb_insn_fetch_stage.sv
// Directed bench for insn_fetch_stage: one default-timeout instance for the
// fetch/update flow and a second instance with a 4-cycle timeout.
`timescale 1ns/1ps
module tb_insn_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ack, upd;
  logic [31:0] rdata, pnext;
  logic        req;
  logic [31:0] addr, pc, insn;
  logic [9:0]  code;
  logic        valid, err;

  logic        reset2;
  logic        ack2, upd2;
  logic [31:0] rdata2, pnext2;
  logic        req2;
  logic [31:0] addr2, pc2, insn2;
  logic [9:0]  code2;
  logic        valid2, err2;

`ifdef FETCH_ILLEGAL_TRAP_EN
  logic ill, ill2;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  insn_fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .imem_req(req), .imem_addr(addr), .imem_ack(ack), .imem_rdata(rdata),
    .pc_update(upd), .pc_next(pnext),
    .pc(pc), .insn(insn), .code(code),
`ifdef FETCH_ILLEGAL_TRAP_EN
    .illegal_insn(ill),
`endif
    .insn_valid(valid), .fetch_err(err)
  );

  insn_fetch_stage #(.RESET_PC(32'h0000_1000), .IMEM_TIMEOUT(4)) dut_to (
    .clk(clk), .reset(reset2),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2), .imem_rdata(rdata2),
    .pc_update(upd2), .pc_next(pnext2),
    .pc(pc2), .insn(insn2), .code(code2),
`ifdef FETCH_ILLEGAL_TRAP_EN
    .illegal_insn(ill2),
`endif
    .insn_valid(valid2), .fetch_err(err2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; reset2 = 1'b1;
    ack = 0; upd = 0; rdata = '0; pnext = '0;
    ack2 = 0; upd2 = 0; rdata2 = '0; pnext2 = '0;
    step(); step();
    n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    n_vec++; if (insn !== 32'h13) begin n_err++; $display("FAIL reset_insn: got %h want %h", insn, 32'h13); end
    n_vec++; if (code !== 10'h0) begin n_err++; $display("FAIL reset_code: got %b want 0", code); end
    n_vec++; if ({req, valid, err} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got req/valid/err=%b want 000", {req, valid, err}); end
    n_vec++; if (addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", addr); end
    n_vec++; if (pc2 !== 32'h1000) begin n_err++; $display("FAIL reset_pc2: got %h want 00001000", pc2); end
  endtask

  task automatic test_first_fetch();
    reset = 1'b0;
    step();  // BOOT -> REQ, first request cycle
    n_vec++; if (req !== 1'b1 || addr !== 32'h0) begin n_err++; $display("FAIL fetch_req1: got req=%b addr=%h want 1/00000000", req, addr); end
    step();  // second request cycle, memory answers now
    ack = 1'b1; rdata = 32'h00500093;
    step();
    ack = 1'b0; rdata = 32'hDEAD_BEEF;
    n_vec++; if (insn !== 32'h00500093) begin n_err++; $display("FAIL fetch_insn: got %h want 00500093", insn); end
    n_vec++; if (code !== 10'b0010000000) begin n_err++; $display("FAIL fetch_code: got %b want 0010000000", code); end
    n_vec++; if (valid !== 1'b1 || req !== 1'b0) begin n_err++; $display("FAIL fetch_valid: got valid=%b req=%b want 1/0", valid, req); end
  endtask

  task automatic test_pc_update();
    // stray ack in VALID must not disturb IR
    ack = 1'b1; rdata = 32'h0000006F;
    step();
    ack = 1'b0;
    n_vec++; if (insn !== 32'h00500093 || valid !== 1'b1) begin n_err++; $display("FAIL valid_hold: got insn=%h valid=%b want 00500093/1", insn, valid); end
    upd = 1'b1; pnext = 32'h00000104;
    step();
    upd = 1'b0; pnext = 32'hFFFF_FFFF;
    n_vec++; if (pc !== 32'h104) begin n_err++; $display("FAIL upd_pc: got %h want 00000104", pc); end
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL upd_valid: got %b want 0", valid); end
    n_vec++; if (req !== 1'b1 || addr !== 32'h104) begin n_err++; $display("FAIL upd_req: got req=%b addr=%h want 1/00000104", req, addr); end
  endtask

  task automatic test_delayed_ack();
    int held = 0;
    for (int i = 0; i < 10; i++) begin
      if (req === 1'b1 && valid === 1'b0 && err === 1'b0) held++;
      step();
    end
    n_vec++; if (held !== 10) begin n_err++; $display("FAIL delay_hold: got %0d req cycles want 10", held); end
    ack = 1'b1; rdata = 32'h00000097;
    step();
    ack = 1'b0;
    n_vec++; if (insn !== 32'h00000097 || code !== 10'b0000000100) begin n_err++; $display("FAIL delay_capture: got insn=%h code=%b want 00000097/0000000100", insn, code); end
    n_vec++; if (valid !== 1'b1 || err !== 1'b0) begin n_err++; $display("FAIL delay_flags: got valid=%b err=%b want 1/0", valid, err); end
  endtask

  task automatic test_misaligned();
    upd = 1'b1; pnext = 32'h00000203;
    step();
    upd = 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
    n_vec++; if (pc !== 32'h0 || ill !== 1'b1) begin n_err++; $display("FAIL misalign_pc: got pc=%h ill=%b want 00000000/1", pc, ill); end
`else
    n_vec++; if (pc !== 32'h200 || addr !== 32'h200) begin n_err++; $display("FAIL misalign_pc: got pc=%h addr=%h want 00000200", pc, addr); end
`endif
  endtask

  task automatic test_illegal();
    ack = 1'b1; rdata = 32'hFFFF_FFFF;
    step();
    ack = 1'b0;
    n_vec++; if (code !== 10'h0 || valid !== 1'b1) begin n_err++; $display("FAIL illegal_code: got code=%b valid=%b want 0/1", code, valid); end
`ifdef FETCH_ILLEGAL_TRAP_EN
    n_vec++; if (ill !== 1'b1) begin n_err++; $display("FAIL illegal_flag: got %b want 1", ill); end
`endif
    upd = 1'b1; pnext = 32'h00000300;
    step();
    upd = 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
    n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL illegal_pc: got %h want 00000000", pc); end
`else
    n_vec++; if (pc !== 32'h300) begin n_err++; $display("FAIL illegal_pc: got %h want 00000300", pc); end
`endif
  endtask

  task automatic test_reset_mid();
    step();
    n_vec++; if (req !== 1'b1) begin n_err++; $display("FAIL mid_pre: got req=%b want 1", req); end
    #2 reset = 1'b1;
    #1;
    n_vec++; if (req !== 1'b0 || valid !== 1'b0) begin n_err++; $display("FAIL mid_async: got req=%b valid=%b want 0/0", req, valid); end
    n_vec++; if (pc !== 32'h0 || addr !== 32'h0) begin n_err++; $display("FAIL mid_pc: got pc=%h addr=%h want 0/0", pc, addr); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_timeout();
    reset2 = 1'b0;
    step();  // REQ cycle 1
    n_vec++; if (req2 !== 1'b1 || addr2 !== 32'h1000) begin n_err++; $display("FAIL to_req: got req=%b addr=%h want 1/00001000", req2, addr2); end
    step(); step(); step();  // REQ cycle 4
    n_vec++; if (err2 !== 1'b0 || req2 !== 1'b1) begin n_err++; $display("FAIL to_early: got err=%b req=%b want 0/1", err2, req2); end
    step();
    n_vec++; if (err2 !== 1'b1 || req2 !== 1'b0) begin n_err++; $display("FAIL to_fire: got err=%b req=%b want 1/0", err2, req2); end
    ack2 = 1'b1; rdata2 = 32'h00500093; upd2 = 1'b1; pnext2 = 32'h40;
    step(); step(); step();
    ack2 = 1'b0; upd2 = 1'b0;
    n_vec++; if (valid2 !== 1'b0 || err2 !== 1'b1 || insn2 !== 32'h13 || pc2 !== 32'h1000) begin n_err++; $display("FAIL to_stuck: got valid=%b err=%b insn=%h pc=%h want 0/1/00000013/00001000", valid2, err2, insn2, pc2); end
    reset2 = 1'b1;
    step();
    n_vec++; if (err2 !== 1'b0 || pc2 !== 32'h1000 || req2 !== 1'b0) begin n_err++; $display("FAIL to_reset: got err=%b pc=%h req=%b want 0/00001000/0", err2, pc2, req2); end
    reset2 = 1'b0;
    step(); step();
    ack2 = 1'b1; rdata2 = 32'h00000073;
    step();
    ack2 = 1'b0;
    n_vec++; if (valid2 !== 1'b1 || code2 !== 10'b1000000000) begin n_err++; $display("FAIL to_recover: got valid=%b code=%b want 1/1000000000", valid2, code2); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_fetch();
    test_pc_update();
    test_delayed_ack();
    test_misaligned();
    test_illegal();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
